// File: rtl/sar_pkg.sv
// Shared types, parameter limits and width helper for the SAR scan controller.
package sar_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    CONV = 1'b1
  } sar_state_e;

  localparam int unsigned WIDTH_MIN  = 2;
  localparam int unsigned WIDTH_MAX  = 16;
  localparam int unsigned NCH_MIN    = 1;
  localparam int unsigned SETTLE_MIN = 1;

  function automatic int unsigned cw_of(input int unsigned nch);
    return (nch > 1) ? $clog2(nch) : 1;
  endfunction

endpackage

// File: rtl/sar_core.sv
// Single-channel successive-approximation engine: trial code, bit index,
// settle counter and the per-bit comparator decision.
module sar_core #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned SETTLE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             clear,
  input  logic             active,
  input  logic             cmp,
  output logic [WIDTH-1:0] dac,
  output logic             fin,
  output logic [WIDTH-1:0] code
);

  localparam int unsigned IW = $clog2(WIDTH);
  localparam int unsigned SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  logic [WIDTH-1:0] dac_q, dac_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [SW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] bit_mask;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dac_q <= '0;
      idx_q <= '0;
      cnt_q <= '0;
    end else begin
      dac_q <= dac_d;
      idx_q <= idx_d;
      cnt_q <= cnt_d;
    end
  end

  always_comb begin
    bit_mask = WIDTH'(1) << idx_q;
    // Resolved value of the bit under test; on the last bit this is the result.
    code     = cmp ? dac_q : (dac_q & ~bit_mask);
    fin      = active && (cnt_q == '0) && (idx_q == '0);
    dac_d    = dac_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    if (load) begin
      dac_d = WIDTH'(1) << (WIDTH - 1);
      idx_d = IW'(WIDTH - 1);
      cnt_d = SW'(SETTLE - 1);
    end else if (clear) begin
      dac_d = '0;
      idx_d = '0;
      cnt_d = '0;
    end else if (active) begin
      if (cnt_q != '0) begin
        cnt_d = cnt_q - SW'(1);
      end else begin
        dac_d = code;
        if (idx_q != '0) begin
          dac_d = code | (bit_mask >> 1);
          idx_d = idx_q - IW'(1);
          cnt_d = SW'(SETTLE - 1);
        end
      end
    end
  end

  assign dac = dac_q;

endmodule

// File: rtl/sar_scan_ctrl.sv
// SAR ADC controller: request handshake, channel sequencing for single/scan
// modes, and result/done/eos registers around the sar_core bit engine.
module sar_scan_ctrl
  import sar_pkg::*;
#(
  parameter  int unsigned WIDTH  = 8,
  parameter  int unsigned NCH    = 4,
  parameter  int unsigned SETTLE = 1,
  localparam int unsigned CW     = cw_of(NCH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             scan,
  input  logic [CW-1:0]    ch_sel,
  input  logic             cmp,
  output logic [WIDTH-1:0] dac,
  output logic [CW-1:0]    ch,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [CW-1:0]    result_ch,
  output logic             eos
);

  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX || NCH < NCH_MIN || SETTLE < SETTLE_MIN) begin : g_bad_param
    $error("sar_scan_ctrl: illegal parameter combination");
  end

  sar_state_e       state_q, state_d;
  logic             scan_q, scan_d;
  logic [CW-1:0]    ch_q, ch_d;
  logic             done_q, done_d;
  logic             eos_q, eos_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [CW-1:0]    result_ch_q, result_ch_d;
  logic             load, clear, fin;
  logic [WIDTH-1:0] code;
  logic [CW-1:0]    ch_clamped;

  sar_core #(
    .WIDTH (WIDTH),
    .SETTLE(SETTLE)
  ) u_core (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (load),
    .clear (clear),
    .active(state_q == CONV),
    .cmp   (cmp),
    .dac   (dac),
    .fin   (fin),
    .code  (code)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      scan_q      <= 1'b0;
      ch_q        <= '0;
      done_q      <= 1'b0;
      eos_q       <= 1'b0;
      result_q    <= '0;
      result_ch_q <= '0;
    end else begin
      state_q     <= state_d;
      scan_q      <= scan_d;
      ch_q        <= ch_d;
      done_q      <= done_d;
      eos_q       <= eos_d;
      result_q    <= result_d;
      result_ch_q <= result_ch_d;
    end
  end

  always_comb begin
    ch_clamped  = (32'(ch_sel) >= NCH) ? CW'(NCH - 1) : ch_sel;
    state_d     = state_q;
    scan_d      = scan_q;
    ch_d        = ch_q;
    done_d      = 1'b0;
    eos_d       = 1'b0;
    result_d    = result_q;
    result_ch_d = result_ch_q;
    load        = 1'b0;
    clear       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          scan_d  = scan;
          ch_d    = scan ? '0 : ch_clamped;
          load    = 1'b1;
          state_d = CONV;
        end
      end
      CONV: begin
        if (fin) begin
          result_d    = code;
          result_ch_d = ch_q;
          done_d      = 1'b1;
          // Next scan channel reloads the engine on the same edge: no idle gap.
          if (scan_q && (32'(ch_q) < NCH - 1)) begin
            ch_d = ch_q + CW'(1);
            load = 1'b1;
          end else begin
            eos_d   = 1'b1;
            clear   = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign ch        = ch_q;
  assign busy      = (state_q == CONV);
  assign done      = done_q;
  assign eos       = eos_q;
  assign result    = result_q;
  assign result_ch = result_ch_q;

endmodule

// File: tb/tb_sar_scan_ctrl.sv
// Directed self-checking bench for sar_scan_ctrl with a behavioural comparator.
module tb_sar_scan_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Main instance: WIDTH=8, NCH=4, SETTLE=2
  logic       start, scan, cmp, busy, done, eos;
  logic [1:0] ch_sel, ch, result_ch;
  logic [7:0] dac, result;
  logic [7:0] vin [4];

  assign cmp = (vin[ch] >= dac);

  sar_scan_ctrl #(.WIDTH(8), .NCH(4), .SETTLE(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .scan(scan), .ch_sel(ch_sel),
    .cmp(cmp), .dac(dac), .ch(ch), .busy(busy), .done(done),
    .result(result), .result_ch(result_ch), .eos(eos)
  );

  // Variant instance: WIDTH=12, NCH=1, SETTLE=1
  logic        start2, scan2, cmp2, busy2, done2, eos2;
  logic [0:0]  ch_sel2, ch2, result_ch2;
  logic [11:0] dac2, result2;
  logic [11:0] vin2;

  assign cmp2 = (vin2 >= dac2);

  sar_scan_ctrl #(.WIDTH(12), .NCH(1), .SETTLE(1)) u_var (
    .clk(clk), .rst_n(rst_n), .start(start2), .scan(scan2), .ch_sel(ch_sel2),
    .cmp(cmp2), .dac(dac2), .ch(ch2), .busy(busy2), .done(done2),
    .result(result2), .result_ch(result_ch2), .eos(eos2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Advances until done is seen or the limit expires; cyc = edges waited.
  task automatic wait_done(input int limit, output int cyc);
    cyc = 0;
    do begin
      tick();
      cyc++;
    end while (!done && cyc < limit);
    check("done_seen", done, 1);
  endtask

  int         cyc, nd, busy_cnt, extra;
  logic [7:0] trials [8];
  logic [7:0] scan_vin [4];

  initial begin
    trials   = '{8'h80, 8'h40, 8'h60, 8'h50, 8'h58, 8'h5C, 8'h5A, 8'h5B};
    scan_vin = '{8'h01, 8'h80, 8'h7F, 8'hFE};
    rst_n = 1'b0; start = 0; scan = 0; ch_sel = 0;
    start2 = 0; scan2 = 0; ch_sel2 = 0; vin2 = 12'hABC;
    vin = '{8'h00, 8'h00, 8'h00, 8'h00};
    tick(); tick();
    check("rst_dac", dac, 0);
    check("rst_ch", ch, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_eos", eos, 0);
    check("rst_result", result, 0);
    check("rst_result_ch", result_ch, 0);
    rst_n = 1'b1;
    tick();

    // Single conversion, ch 2, vin 0x5A: trace every trial code
    vin[2] = 8'h5A;
    start = 1; scan = 0; ch_sel = 2;
    tick();
    start = 0;
    check("s1_busy", busy, 1);
    check("s1_ch", ch, 2);
    check("s1_trial0", dac, 8'h80);
    tick();
    check("s1_hold", dac, 8'h80);
    for (int k = 1; k < 8; k++) begin
      tick();
      check($sformatf("s1_trial%0d", k), dac, trials[k]);
      check("s1_no_done", done, 0);
      tick();
    end
    tick();
    check("s1_done", done, 1);
    check("s1_result", result, 8'h5A);
    check("s1_result_ch", result_ch, 2);
    check("s1_eos", eos, 1);
    check("s1_busy_fall", busy, 0);
    check("s1_dac_idle", dac, 0);
    tick();
    check("s1_done_pulse", done, 0);
    check("s1_eos_pulse", eos, 0);
    check("s1_result_held", result, 8'h5A);

    // Extremes
    vin[0] = 8'h00; start = 1; ch_sel = 0; tick(); start = 0;
    wait_done(40, cyc);
    check("zero_latency", cyc, 16);
    check("zero_result", result, 8'h00);
    tick();
    vin[1] = 8'hFF; start = 1; ch_sel = 1; tick(); start = 0;
    wait_done(40, cyc);
    check("ff_latency", cyc, 16);
    check("ff_result", result, 8'hFF);
    check("ff_result_ch", result_ch, 1);
    tick();

    // Full scan
    for (int i = 0; i < 4; i++) vin[i] = scan_vin[i];
    start = 1; scan = 1; ch_sel = 2; tick(); start = 0; scan = 0;
    check("scan_first_ch", ch, 0);
    cyc = 0; nd = 0; busy_cnt = 0;
    while (busy && cyc < 200) begin
      busy_cnt++;
      tick();
      cyc++;
      if (done) begin
        check("scan_spacing", cyc, 16 * (nd + 1));
        check("scan_result_ch", result_ch, nd);
        check("scan_result", result, scan_vin[nd]);
        check("scan_eos", eos, (nd == 3) ? 1 : 0);
        nd++;
      end
    end
    check("scan_done_count", nd, 4);
    check("scan_busy_cycles", busy_cnt, 64);
    tick();

    // start pulsed mid-conversion is ignored
    vin[0] = 8'h44; start = 1; scan = 0; ch_sel = 0; tick(); start = 0;
    repeat (5) tick();
    start = 1; scan = 1; ch_sel = 3; tick(); start = 0; scan = 0;
    wait_done(40, cyc);
    check("ign_latency", cyc, 10);
    check("ign_result", result, 8'h44);
    check("ign_result_ch", result_ch, 0);
    check("ign_eos", eos, 1);
    extra = 0;
    repeat (20) begin
      tick();
      if (done || busy) extra++;
    end
    check("ign_no_extra", extra, 0);

    // start held high re-triggers one cycle after busy falls
    vin[3] = 8'hC3; start = 1; ch_sel = 3; tick();
    wait_done(40, cyc);
    check("held_latency", cyc, 16);
    check("held_busy_low", busy, 0);
    tick();
    check("held_retrigger", busy, 1);
    check("held_dac", dac, 8'h80);
    start = 0;
    wait_done(40, cyc);
    check("held_result", result, 8'hC3);
    check("held_result_ch", result_ch, 3);

    // Reset during conversion
    vin[1] = 8'h80; start = 1; ch_sel = 1; tick(); start = 0;
    repeat (4) tick();
    rst_n = 1'b0;
    #1;
    check("mrst_dac", dac, 0);
    check("mrst_busy", busy, 0);
    check("mrst_ch", ch, 0);
    check("mrst_result", result, 0);
    check("mrst_result_ch", result_ch, 0);
    check("mrst_done", done, 0);
    tick();
    rst_n = 1'b1;
    extra = 0;
    repeat (20) begin
      tick();
      if (done || busy) extra++;
    end
    check("mrst_no_done", extra, 0);
    vin[1] = 8'h33; start = 1; ch_sel = 1; tick(); start = 0;
    wait_done(40, cyc);
    check("mrst_new_latency", cyc, 16);
    check("mrst_new_result", result, 8'h33);
    tick();

    // Variant: WIDTH=12, SETTLE=1, NCH=1, out-of-range ch_sel clamps to 0
    start2 = 1; scan2 = 0; ch_sel2 = 1; tick(); start2 = 0;
    check("var_busy", busy2, 1);
    check("var_ch", ch2, 0);
    check("var_trial0", dac2, 12'h800);
    cyc = 0;
    do begin
      tick();
      cyc++;
    end while (!done2 && cyc < 40);
    check("var_done", done2, 1);
    check("var_latency", cyc, 12);
    check("var_result", result2, 12'hABC);
    check("var_result_ch", result_ch2, 0);
    check("var_eos", eos2, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
